// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two datapath stages.
// A main register drives the outputs and a skid register catches the one word
// accepted in the cycle downstream first stalls, so in_ready is a pure
// register decode. Flush empties the stage and drops that cycle's input.
// A saturating counter records how many cycles the output was backpressured.
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_skid_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_main_valid;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_stall;

    assign w_main_valid = (r_state != ST_EMPTY);

    // Data-path load enables; a flush suppresses every load so the dropped
    // input never lands in either register.
    assign w_load_main_in   = !flush && in_valid &&
                              ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && out_ready));
    assign w_load_skid      = !flush && in_valid && (r_state == ST_ONE) && !out_ready;
    assign w_load_main_skid = !flush && (r_state == ST_FULL) && out_ready;

    // A stall is counted on live-but-refused cycles, including flush cycles.
    assign w_stall = w_main_valid && !out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; flush overrides every handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (in_valid) w_state_next = ST_ONE;
            end
            ST_ONE: begin
                if (in_valid && !out_ready)      w_state_next = ST_FULL;
                else if (!in_valid && out_ready) w_state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_ready) w_state_next = ST_ONE;
            end
            default: w_state_next = ST_EMPTY;
        endcase
        if (flush) w_state_next = ST_EMPTY;
    end

    // Output decode from the state register only; control is masked when empty.
    always_comb begin
        in_ready  = (r_state != ST_FULL);
        out_valid = w_main_valid;
        out_data  = r_main_data;
        out_ctrl  = w_main_valid ? r_main_ctrl : '0;
        stall_cnt = r_stall_cnt;
    end

    // Main and skid registers; main refills from skid first to keep FIFO order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end else if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: reset, streaming, skid backpressure,
// flush, counter saturation/clear (second instance with CNT_W=3) and
// asynchronous reset while full.
module tb_pipe_stage_elastic;

    localparam int DW = 32;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          stat_clr;

    logic          in_ready_a, out_valid_a;
    logic [DW-1:0] out_data_a;
    logic [CW-1:0] out_ctrl_a;
    logic [15:0]   stall_cnt_a;

    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [CW-1:0] out_ctrl_b;
    logic [2:0]    stall_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ctrl(out_ctrl_a),
        .stat_clr(stat_clr), .stall_cnt(stall_cnt_a)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ctrl(out_ctrl_b),
        .stat_clr(stat_clr), .stall_cnt(stall_cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the full output view of the default-width instance.
    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [CW-1:0] c, input logic rdy, input logic [15:0] cnt);
        chk({tag, ".out_valid"}, 64'(out_valid_a), 64'(v));
        if (v) chk({tag, ".out_data"}, 64'(out_data_a), 64'(d));
        chk({tag, ".out_ctrl"}, 64'(out_ctrl_a), 64'(c));
        chk({tag, ".in_ready"}, 64'(in_ready_a), 64'(rdy));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt_a), 64'(cnt));
        $display("step %-12s v=%0b d=%08h c=%03h rdy=%0b cnt=%0d", tag,
                 out_valid_a, out_data_a, out_ctrl_a, in_ready_a, stall_cnt_a);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; stat_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Reset held with random inputs: outputs pinned to reset values.
        for (int i = 0; i < 4; i++) begin
            flush    = 1'($urandom);
            stat_clr = 1'($urandom);
            drive(1'($urandom), $urandom, CW'($urandom), 1'($urandom));
            @(negedge clk);
            chk_out("rst_hold", 1'b0, '0, '0, 1'b1, 16'd0);
            chk("rst_hold.out_data", 64'(out_data_a), 64'd0);
        end

        // Release and send one word.
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; stat_clr = 1'b0;
        drive(1'b1, 32'h1234, 9'h005, 1'b1);
        @(negedge clk);
        chk_out("first_word", 1'b1, 32'h1234, 9'h005, 1'b1, 16'd0);
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk_out("first_drain", 1'b0, '0, '0, 1'b1, 16'd0);

        // Streaming 0..7 back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i), CW'(i + 16), 1'b1);
            @(negedge clk);
            chk_out("stream", 1'b1, DW'(i), CW'(i + 16), 1'b1, 16'd0);
        end
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk_out("stream_end", 1'b0, '0, '0, 1'b1, 16'd0);

        // Backpressure: A on output, stall while B arrives, C held upstream.
        drive(1'b1, 32'hA, 9'h0A1, 1'b1);
        @(negedge clk);
        chk_out("bp_A", 1'b1, 32'hA, 9'h0A1, 1'b1, 16'd0);
        drive(1'b1, 32'hB, 9'h0B2, 1'b0);
        @(negedge clk);
        chk_out("bp_full1", 1'b1, 32'hA, 9'h0A1, 1'b0, 16'd1);
        drive(1'b1, 32'hC, 9'h0C3, 1'b0);
        @(negedge clk);
        chk_out("bp_full2", 1'b1, 32'hA, 9'h0A1, 1'b0, 16'd2);
        drive(1'b1, 32'hC, 9'h0C3, 1'b1);
        @(negedge clk);
        chk_out("bp_B", 1'b1, 32'hB, 9'h0B2, 1'b1, 16'd2);
        @(negedge clk);
        chk_out("bp_C", 1'b1, 32'hC, 9'h0C3, 1'b1, 16'd2);
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk_out("bp_empty", 1'b0, '0, '0, 1'b1, 16'd2);

        // Flush in FULL with an input presented; the flush cycle is a stall.
        drive(1'b1, 32'hD0, 9'h1D0, 1'b0);
        @(negedge clk);
        chk_out("fl_D", 1'b1, 32'hD0, 9'h1D0, 1'b1, 16'd2);
        drive(1'b1, 32'hE0, 9'h1E0, 1'b0);
        @(negedge clk);
        chk_out("fl_full", 1'b1, 32'hD0, 9'h1D0, 1'b0, 16'd3);
        flush = 1'b1;
        drive(1'b1, 32'hF0, 9'h1F0, 1'b0);
        @(negedge clk);
        chk_out("fl_done", 1'b0, '0, '0, 1'b1, 16'd4);
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk_out("fl_idle", 1'b0, '0, '0, 1'b1, 16'd4);
        drive(1'b1, 32'h60, 9'h060, 1'b1);
        @(negedge clk);
        chk_out("fl_next", 1'b1, 32'h60, 9'h060, 1'b1, 16'd4);
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk_out("fl_next_out", 1'b0, '0, '0, 1'b1, 16'd4);

        // Flush in ONE with in_valid.
        drive(1'b1, 32'h70, 9'h070, 1'b0);
        @(negedge clk);
        chk_out("fl1_H", 1'b1, 32'h70, 9'h070, 1'b1, 16'd4);
        flush = 1'b1;
        drive(1'b1, 32'h71, 9'h071, 1'b1);
        @(negedge clk);
        chk_out("fl1_done", 1'b0, '0, '0, 1'b1, 16'd4);
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);

        // Clear both counters, then saturation on the 3-bit instance.
        stat_clr = 1'b1;
        @(negedge clk);
        chk("clr.cnt_a", 64'(stall_cnt_a), 64'd0);
        chk("clr.cnt_b", 64'(stall_cnt_b), 64'd0);
        stat_clr = 1'b0;
        drive(1'b1, 32'h99, 9'h099, 1'b0);
        @(negedge clk);
        chk("sat_load.cnt_b", 64'(stall_cnt_b), 64'd0);
        chk("sat_load.valid_b", 64'(out_valid_b), 64'd1);
        drive(1'b0, '0, '0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("sat.cnt_b", 64'(stall_cnt_b), 64'((k > 7) ? 7 : k));
            chk("sat.cnt_a", 64'(stall_cnt_a), 64'(k));
            $display("sat k=%0d cnt_a=%0d cnt_b=%0d", k, stall_cnt_a, stall_cnt_b);
        end
        stat_clr = 1'b1;
        @(negedge clk);
        chk("clr_stall.cnt_b", 64'(stall_cnt_b), 64'd0);
        chk("clr_stall.cnt_a", 64'(stall_cnt_a), 64'd0);
        stat_clr = 1'b0;
        @(negedge clk);
        chk("after_clr.cnt_b", 64'(stall_cnt_b), 64'd1);
        chk("after_clr.cnt_a", 64'(stall_cnt_a), 64'd1);

        // Fill to FULL, then pulse reset between edges.
        drive(1'b1, 32'hAB, 9'h0AB, 1'b0);
        @(negedge clk);
        chk_out("ar_full", 1'b1, 32'h99, 9'h099, 1'b0, 16'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_out("ar_async", 1'b0, '0, '0, 1'b1, 16'd0);
        chk("ar_async.out_data", 64'(out_data_a), 64'd0);
        chk("ar_async.cnt_b", 64'(stall_cnt_b), 64'd0);
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_out("ar_after", 1'b0, '0, '0, 1'b1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
